// File: rtl/multi_debounce.sv
`default_nettype none
// ============================================================================
// Module   : multi_debounce
// Purpose  : N-channel push-button conditioner: debounced level, press/release
//            pulses and optional hold-to-repeat pulse train per channel.
// Revision : 1.0 - initial release
// ============================================================================
module multi_debounce #(
  parameter int N_CH          = 4,
  parameter int CNT_W         = 16,
  parameter int STABLE_CNT    = 50000,
  parameter int ACTIVE_LOW    = 0,
  parameter int REPEAT_EN     = 1,
  parameter int HOLD_W        = 28,
  parameter int HOLD_DELAY    = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] noisy_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  localparam logic              c_idle_phys = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0]  c_cnt_last  = CNT_W'(STABLE_CNT - 1);
  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(HOLD_DELAY - 1);
  localparam logic [HOLD_W-1:0] c_per_last  = HOLD_W'(REPEAT_PERIOD - 1);
  localparam longint            c_hc_span   = (HOLD_DELAY > REPEAT_PERIOD) ?
                                              longint'(HOLD_DELAY) : longint'(REPEAT_PERIOD);

  if (STABLE_CNT < 1 || longint'(STABLE_CNT) > ((longint'(1) << CNT_W) - 1)) begin : g_chk_stable
    $fatal(1, "multi_debounce: STABLE_CNT out of range for CNT_W");
  end
  if (HOLD_DELAY < 1 || REPEAT_PERIOD < 1 || c_hc_span > (longint'(1) << HOLD_W)) begin : g_chk_hold
    $fatal(1, "multi_debounce: HOLD_DELAY/REPEAT_PERIOD out of range for HOLD_W");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } hold_state_e;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic             r_s0, r_s1, r_level, r_press, r_release;
    logic [CNT_W-1:0] r_cnt;
    logic             w_s, w_accept, w_press, w_release;

    // Synchroniser idles at the released level so reset exit never looks like a press
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s0 <= c_idle_phys;
        r_s1 <= c_idle_phys;
      end else begin
        r_s0 <= noisy_in[g];
        r_s1 <= r_s0;
      end
    end

    assign w_s       = r_s1 ^ c_idle_phys;
    assign w_accept  = (w_s != r_level) && (r_cnt == c_cnt_last);
    assign w_press   = w_accept & w_s;
    assign w_release = w_accept & ~w_s;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_cnt     <= '0;
      end else begin
        r_press   <= w_press;
        r_release <= w_release;
        if (w_s == r_level || w_accept) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        if (w_accept) begin
          r_level <= w_s;
        end
      end
    end

    assign level_out[g]     = r_level;
    assign press_pulse[g]   = r_press;
    assign release_pulse[g] = r_release;

    if (REPEAT_EN != 0) begin : g_rep
      hold_state_e       r_state, w_state_nxt;
      logic [HOLD_W-1:0] r_hc, w_hc_nxt;
      logic              r_rep, w_rep_nxt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state <= ST_IDLE;
          r_hc    <= '0;
          r_rep   <= 1'b0;
        end else begin
          r_state <= w_state_nxt;
          r_hc    <= w_hc_nxt;
          r_rep   <= w_rep_nxt;
        end
      end

      // Release has priority so no repeat can share the release cycle
      always_comb begin
        w_state_nxt = r_state;
        w_hc_nxt    = r_hc;
        w_rep_nxt   = 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (w_press) begin
              w_state_nxt = ST_HOLD;
              w_hc_nxt    = '0;
            end
          end
          ST_HOLD: begin
            if (w_release) begin
              w_state_nxt = ST_IDLE;
              w_hc_nxt    = '0;
            end else if (r_hc == c_hold_last) begin
              w_state_nxt = ST_REPEAT;
              w_hc_nxt    = '0;
              w_rep_nxt   = 1'b1;
            end else begin
              w_hc_nxt = r_hc + HOLD_W'(1);
            end
          end
          ST_REPEAT: begin
            if (w_release) begin
              w_state_nxt = ST_IDLE;
              w_hc_nxt    = '0;
            end else if (r_hc == c_per_last) begin
              w_hc_nxt  = '0;
              w_rep_nxt = 1'b1;
            end else begin
              w_hc_nxt = r_hc + HOLD_W'(1);
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_hc_nxt    = '0;
          end
        endcase
      end

      assign repeat_pulse[g] = r_rep;
    end else begin : g_no_rep
      assign repeat_pulse[g] = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_debounce
// Purpose  : Self-checking bench for multi_debounce (active-high and active-low
//            instances driven with the same logical button activity).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_debounce;

  localparam int N_CH   = 2;
  localparam int CNT_W  = 8;
  localparam int STABLE = 8;
  localparam int HOLD_W = 8;
  localparam int HD     = 20;
  localparam int RP     = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] noisy = '0;
  logic [N_CH-1:0] noisy_l;
  logic [N_CH-1:0] lvl_h, prs_h, rel_h, rep_h;
  logic [N_CH-1:0] lvl_l, prs_l, rel_l, rep_l;

  assign noisy_l = ~noisy;

  always #5 clk = ~clk;

  multi_debounce #(
    .N_CH(N_CH), .CNT_W(CNT_W), .STABLE_CNT(STABLE), .ACTIVE_LOW(0), .REPEAT_EN(1),
    .HOLD_W(HOLD_W), .HOLD_DELAY(HD), .REPEAT_PERIOD(RP)
  ) dut_h (
    .clk(clk), .rst(rst), .noisy_in(noisy), .level_out(lvl_h),
    .press_pulse(prs_h), .release_pulse(rel_h), .repeat_pulse(rep_h)
  );

  multi_debounce #(
    .N_CH(N_CH), .CNT_W(CNT_W), .STABLE_CNT(STABLE), .ACTIVE_LOW(1), .REPEAT_EN(1),
    .HOLD_W(HOLD_W), .HOLD_DELAY(HD), .REPEAT_PERIOD(RP)
  ) dut_l (
    .clk(clk), .rst(rst), .noisy_in(noisy_l), .level_out(lvl_l),
    .press_pulse(prs_l), .release_pulse(rel_l), .repeat_pulse(rep_l)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: sample history window plus "cycles since press" arithmetic
  int              hist [N_CH][STABLE+1];
  int              m_lvl [N_CH];
  int              since [N_CH];
  logic [N_CH-1:0] e_lvl, e_prs, e_rel, e_rep;

  int cnt [2][3][N_CH];   // [dut][press/release/repeat][channel]

  typedef struct {
    logic [1:0]  pat;
    int          cycles;
    logic [23:0] exp_cnt;   // nibbles: prs0 prs1 rel0 rel1 rep0 rep1
  } phase_t;
  phase_t phases [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      for (int i = 0; i <= STABLE; i++) hist[c][i] = 0;
      m_lvl[c] = 0;
      since[c] = -1;
    end
    e_lvl = '0; e_prs = '0; e_rel = '0; e_rep = '0;
  endtask

  task automatic model_edge();
    bit accept;
    e_prs = '0; e_rel = '0; e_rep = '0;
    for (int c = 0; c < N_CH; c++) begin
      // Accept when the last STABLE synchronised samples all disagree with the level
      accept = 1'b1;
      for (int i = 1; i <= STABLE; i++) if (hist[c][i] == m_lvl[c]) accept = 1'b0;
      for (int i = STABLE; i >= 1; i--) hist[c][i] = hist[c][i-1];
      hist[c][0] = int'(noisy[c]);
      if (accept) begin
        if (m_lvl[c] == 0) begin
          e_prs[c] = 1'b1;
          since[c] = 0;
        end else begin
          e_rel[c] = 1'b1;
          since[c] = -1;
        end
        m_lvl[c] = 1 - m_lvl[c];
      end else if (since[c] >= 0) begin
        since[c]++;
        if (since[c] >= HD && ((since[c] - HD) % RP) == 0) e_rep[c] = 1'b1;
      end
      e_lvl[c] = (m_lvl[c] != 0);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_h"}, {24'd0, lvl_h, prs_h, rel_h, rep_h}, {24'd0, e_lvl, e_prs, e_rel, e_rep});
    check({tag, "_l"}, {24'd0, lvl_l, prs_l, rel_l, rep_l}, {24'd0, e_lvl, e_prs, e_rel, e_rep});
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < N_CH; c++) cnt[d][k][c] = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    check_outputs("cycle");
    for (int c = 0; c < N_CH; c++) begin
      cnt[0][0][c] += int'(prs_h[c]); cnt[0][1][c] += int'(rel_h[c]); cnt[0][2][c] += int'(rep_h[c]);
      cnt[1][0][c] += int'(prs_l[c]); cnt[1][1][c] += int'(rel_l[c]); cnt[1][2][c] += int'(rep_l[c]);
    end
  endtask

  function automatic logic [23:0] pack_counts(input int d);
    return {4'(cnt[d][0][0]), 4'(cnt[d][0][1]), 4'(cnt[d][1][0]),
            4'(cnt[d][1][1]), 4'(cnt[d][2][0]), 4'(cnt[d][2][1])};
  endfunction

  task automatic wait_pulse(input int ch, input int kind, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if ((kind == 0 && prs_h[ch]) || (kind == 1 && rel_h[ch]) || (kind == 2 && rep_h[ch])) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs("async_reset");
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int rep_off [8];
    int rep_n;
    int thresh;

    phases[0] = '{2'b00, 12, 24'h000000};
    phases[1] = '{2'b01,  7, 24'h000000};
    phases[2] = '{2'b00, 12, 24'h000000};
    phases[3] = '{2'b01, 40, 24'h100030};
    phases[4] = '{2'b00, 30, 24'h001010};
    phases[5] = '{2'b10, 70, 24'h010009};
    phases[6] = '{2'b00, 30, 24'h000101};
    phases[7] = '{2'b11, 15, 24'h110000};
    phases[8] = '{2'b00, 20, 24'h001100};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state_h", {24'd0, lvl_h, prs_h, rel_h, rep_h}, 32'd0);
    check("reset_state_l", {24'd0, lvl_l, prs_l, rel_l, rep_l}, 32'd0);
    rst = 1'b0;

    // Idle out of reset: active-low instance sees a high input and must stay quiet
    clear_counts();
    repeat (20) tick();
    check("idle_no_press_l", pack_counts(1), 24'h0);

    for (int p = 0; p < 9; p++) begin
      clear_counts();
      noisy = phases[p].pat;
      repeat (phases[p].cycles) tick();
      check($sformatf("phase%0d_counts_h", p), {8'd0, pack_counts(0)}, {8'd0, phases[p].exp_cnt});
      check($sformatf("phase%0d_counts_l", p), {8'd0, pack_counts(1)}, {8'd0, phases[p].exp_cnt});
    end

    // Clean press then release on channel 0
    noisy = 2'b01;
    wait_pulse(0, 0, 40, n);
    check("clean_press_latency", n, 10);
    repeat (30) tick();
    noisy = 2'b00;
    wait_pulse(0, 1, 40, n);
    check("release_latency", n, 10);
    clear_counts();
    repeat (30) tick();
    check("no_repeat_after_release", cnt[0][2][0], 0);

    // Bounce: 7 high / 1 low x4 never reaches the threshold
    clear_counts();
    for (int k = 0; k < 4; k++) begin
      noisy = 2'b01; repeat (7) tick();
      noisy = 2'b00; tick();
    end
    check("bounce_no_press", cnt[0][0][0], 0);
    noisy = 2'b01;
    wait_pulse(0, 0, 40, n);
    check("bounce_final_press", n, 10);
    noisy = 2'b00;
    repeat (25) tick();

    // Auto-repeat on channel 1
    noisy = 2'b10;
    wait_pulse(1, 0, 40, n);
    check("ch1_press_latency", n, 10);
    rep_n = 0;
    for (int t = 1; t <= 57; t++) begin
      tick();
      if (rep_h[1]) begin
        if (rep_n < 8) rep_off[rep_n] = t;
        rep_n++;
      end
    end
    check("repeat_count", rep_n, 8);
    for (int j = 0; j < 8 && j < rep_n; j++) check($sformatf("repeat_offset%0d", j), rep_off[j], HD + RP * j);
    noisy = 2'b00;
    wait_pulse(1, 1, 40, n);
    check("ch1_release_latency", n, 10);
    clear_counts();
    repeat (30) tick();
    check("ch1_no_repeat_after_release", cnt[0][2][1], 0);

    // Simultaneous press, then reset mid-repeat with inputs still held
    noisy = 2'b11;
    wait_pulse(0, 0, 40, n);
    check("simul_press_latency", n, 10);
    check("simul_press_both_h", prs_h, 2'b11);
    check("simul_press_both_l", prs_l, 2'b11);
    repeat (24) tick();
    rst = 1'b1;
    model_reset();
    #1;
    check("midrepeat_reset_h", {24'd0, lvl_h, prs_h, rel_h, rep_h}, 32'd0);
    check("midrepeat_reset_l", {24'd0, lvl_l, prs_l, rel_l, rep_l}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    wait_pulse(0, 0, 40, n);
    check("post_reset_press_latency", n, 10);
    check("post_reset_press_both", prs_h, 2'b11);
    wait_pulse(0, 2, 40, n);
    check("post_reset_first_repeat", n, HD);
    noisy = 2'b00;
    repeat (25) tick();

    // Randomised activity against the model, short and long hold regimes
    for (int i = 0; i < 3000; i++) begin
      thresh = (i < 1500) ? 11 : 49;
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, thresh) == 0) noisy[c] = ~noisy[c];
      if ($urandom_range(0, 999) == 0) pulse_reset();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
